// File: rtl/canny_frame_ctrl.sv
// canny_frame_ctrl: frame/line sequencer that feeds active-low fval/lval timing and pixels to canny_edge_detection.
// Defining CANNY_CTRL_OUT_MON_EN adds a monitor that counts output lines per frame and flags mismatches on mon_err.
module canny_frame_ctrl #(
  parameter int DW            = 16,
  parameter int H_ACTIVE      = 640,
  parameter int H_BLANK       = 80,
  parameter int V_ACTIVE      = 512,
  parameter int V_BLANK       = 4,
  parameter int EXP_OUT_LINES = 504
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
  input  logic          en_req,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          src_ready,
  output logic          en_fun,
  output logic          b_fval,
  output logic          b_lval,
  output logic [DW-1:0] in_data,
  input  logic          b_fval_sync,
  input  logic          b_lval_sync,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun,
  output logic          mon_err
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int VB_CYC  = (V_BLANK == 0) ? 1 : V_BLANK * H_TOTAL;
  localparam int CW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int RW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int VW      = (VB_CYC > 1) ? $clog2(VB_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_LINE   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [VW-1:0]   r_vcnt;
  logic            r_stop_pend;
  logic            r_last_d;
  logic            r_b_fval, r_b_lval, r_en_fun, r_frame_done, r_underrun;
  logic [DW-1:0]   r_in_data;

  logic w_start_acc, w_active, w_col_last, w_frame_last, w_vb_last, w_continue;

  assign w_start_acc  = (r_state == S_IDLE) && start;
  assign w_active     = (r_state == S_LINE) && (r_col >= CW'(H_BLANK));
  assign w_col_last   = (r_col == CW'(H_TOTAL - 1));
  assign w_frame_last = (r_state == S_LINE) && w_col_last && (r_row == RW'(V_ACTIVE - 1));
  assign w_vb_last    = (r_state == S_VBLANK) && (r_vcnt == VW'(VB_CYC - 1));
  // A stop seen at any point of the frame (or with the start) ends the sequence after this frame.
  assign w_continue   = cont && !stop && !r_stop_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_VBLANK; else w_state_nxt = S_IDLE;
      S_VBLANK: if (w_vb_last) w_state_nxt = S_LINE; else w_state_nxt = S_VBLANK;
      S_LINE: begin
        if (w_frame_last) w_state_nxt = w_continue ? S_VBLANK : S_IDLE;
        else              w_state_nxt = S_LINE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_vcnt      <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_vcnt <= (r_state == S_VBLANK && !w_vb_last) ? r_vcnt + VW'(1) : VW'(0);
      if (r_state == S_LINE) begin
        r_col <= w_col_last ? CW'(0) : r_col + CW'(1);
        if (w_col_last) r_row <= w_frame_last ? RW'(0) : r_row + RW'(1);
      end else begin
        r_col <= '0;
        r_row <= '0;
      end
      if (w_start_acc)             r_stop_pend <= stop;
      else if (w_frame_last)       r_stop_pend <= 1'b0;
      else if (r_state != S_IDLE)  r_stop_pend <= r_stop_pend | stop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_fval     <= 1'b1;
      r_b_lval     <= 1'b1;
      r_in_data    <= '0;
      r_en_fun     <= 1'b0;
      r_last_d     <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_b_fval     <= (r_state != S_LINE);
      r_b_lval     <= !w_active;
      r_in_data    <= (w_active && src_valid) ? src_data : {DW{1'b0}};
      // frame_done trails the last pixel's appearance on in_data by one cycle.
      r_last_d     <= w_frame_last;
      r_frame_done <= r_last_d;
      if (w_start_acc || (w_frame_last && w_continue)) r_en_fun <= en_req;
      if (w_start_acc)                  r_underrun <= 1'b0;
      else if (w_active && !src_valid)  r_underrun <= 1'b1;
    end
  end

  assign src_ready  = w_active;
  assign busy       = (r_state != S_IDLE);
  assign b_fval     = r_b_fval;
  assign b_lval     = r_b_lval;
  assign in_data    = r_in_data;
  assign en_fun     = r_en_fun;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

`ifdef CANNY_CTRL_OUT_MON_EN
  localparam int MCW = $clog2(EXP_OUT_LINES + V_ACTIVE + 2);

  logic           r_fs_d, r_ls_d, r_mon_err;
  logic [MCW-1:0] r_lcnt;
  logic           w_fs_rise, w_ls_fall;

  assign w_fs_rise = !r_fs_d && b_fval_sync;
  assign w_ls_fall = r_ls_d && !b_lval_sync && !b_fval_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fs_d    <= 1'b1;
      r_ls_d    <= 1'b1;
      r_lcnt    <= '0;
      r_mon_err <= 1'b0;
    end else begin
      r_fs_d <= b_fval_sync;
      r_ls_d <= b_lval_sync;
      if (w_fs_rise)      r_lcnt <= '0;
      else if (w_ls_fall) r_lcnt <= r_lcnt + MCW'(1);
      if (w_start_acc)                                    r_mon_err <= 1'b0;
      else if (w_fs_rise && r_lcnt != MCW'(EXP_OUT_LINES)) r_mon_err <= 1'b1;
    end
  end

  assign mon_err = r_mon_err;
`else
  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, b_fval_sync, b_lval_sync};
  assign mon_err       = 1'b0;
`endif

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Randomized bench for canny_frame_ctrl: a frame-position reference model predicts every output each cycle.
// Monitor scenarios run only when CANNY_CTRL_OUT_MON_EN is defined.
module tb_canny_frame_ctrl;
  localparam int DW = 16, HA = 8, HB = 2, VA = 4, VB = 1, EXP = 3;
  localparam int HT = HA + HB;
  localparam int VBC = (VB == 0) ? 1 : VB * HT;
  localparam int LINE_CYC = VA * HT;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, cont = 1'b0, en_req = 1'b0, src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic b_fval_sync = 1'b1, b_lval_sync = 1'b1;
  logic src_ready, en_fun, b_fval, b_lval, busy, frame_done, underrun, mon_err;
  logic [DW-1:0] in_data;

  canny_frame_ctrl #(.DW(DW), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                     .EXP_OUT_LINES(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont), .en_req(en_req),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready), .en_fun(en_fun),
    .b_fval(b_fval), .b_lval(b_lval), .in_data(in_data), .b_fval_sync(b_fval_sync),
    .b_lval_sync(b_lval_sync), .busy(busy), .frame_done(frame_done), .underrun(underrun),
    .mon_err(mon_err));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, fd_cnt = 0;

  // Model: position within the current frame plus the flags the spec defines.
  bit m_run, m_stop_pend, m_en, m_under, m_mon, m_fd1;
  int m_pos;
  bit e_fval, e_lval, e_fd;
  logic [DW-1:0] e_data;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_stop_pend = 0; m_en = 0; m_under = 0; m_mon = 0; m_fd1 = 0; m_pos = 0;
    e_fval = 1; e_lval = 1; e_fd = 0; e_data = '0;
  endtask

  // Called at a negedge with inputs already driven; advances one clock and checks all outputs.
  task automatic cycle();
    bit in_line, active, last;
    int lpos;
    in_line = m_run && (m_pos >= VBC);
    lpos    = m_pos - VBC;
    active  = in_line && ((lpos % HT) >= HB);
    last    = in_line && (lpos == LINE_CYC - 1);
    check_eq("src_ready", src_ready, active);
    e_fd   = m_fd1;
    m_fd1  = last;
    e_fval = !in_line;
    e_lval = !active;
    e_data = (active && src_valid) ? src_data : '0;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_pos = 0; m_stop_pend = stop; m_en = en_req; m_under = 0; m_mon = 0;
      end
    end else begin
      if (active && !src_valid) m_under = 1;
      if (last) begin
        if (cont && !stop && !m_stop_pend) begin m_pos = 0; m_en = en_req; end
        else begin m_run = 0; m_stop_pend = 0; end
      end else begin
        m_pos++;
        m_stop_pend |= stop;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("b_fval", b_fval, e_fval);
    check_eq("b_lval", b_lval, e_lval);
    check_eq("in_data", in_data, e_data);
    check_eq("frame_done", frame_done, e_fd);
    check_eq("busy", busy, m_run);
    check_eq("en_fun", en_fun, m_en);
    check_eq("underrun", underrun, m_under);
    check_eq("mon_err", mon_err, m_mon);
    if (frame_done) fd_cnt++;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_fval"}, b_fval, 1'b1);
    check_eq({tag, "_lval"}, b_lval, 1'b1);
    check_eq({tag, "_data"}, in_data, 16'h0);
    check_eq({tag, "_en"}, en_fun, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_fd"}, frame_done, 1'b0);
    check_eq({tag, "_under"}, underrun, 1'b0);
    check_eq({tag, "_mon"}, mon_err, 1'b0);
  endtask

`ifdef CANNY_CTRL_OUT_MON_EN
  task automatic mon_frame(input int n);
    b_fval_sync = 1'b1; b_lval_sync = 1'b1; cycle();
    b_fval_sync = 1'b0; cycle();
    for (int l = 0; l < n; l++) begin
      b_lval_sync = 1'b1; cycle(); cycle();
      b_lval_sync = 1'b0; cycle(); cycle(); cycle();
    end
    b_lval_sync = 1'b1; cycle();
    b_fval_sync = 1'b1;
    if (n != EXP) m_mon = 1;
    cycle();
    cycle();
  endtask
`endif

  initial begin
    logic [DW-1:0] ramp;
    int stop_at, drop_pos;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("t1_reset");
    rst_n = 1'b1;
    cycle();

    // Single frame, source always valid, ramp data.
    ramp = 16'h0100; src_valid = 1'b1; en_req = 1'b1; cont = 1'b0;
    fd_cnt = 0;
    for (int i = 0; i < VBC + LINE_CYC + 8; i++) begin
      start = (i == 0); src_data = ramp; ramp = ramp + 16'd1;
      cycle();
    end
    check_eq("t2_fd_count", fd_cnt, 1);
    check_eq("t2_idle", busy, 1'b0);
    check_eq("t2_underrun", underrun, 1'b0);

    // One dropped pixel at column 5 of row 2.
    drop_pos = VBC + 2 * HT + 5;
    en_req = 1'b0;
    for (int i = 0; i < VBC + LINE_CYC + 6; i++) begin
      start = (i == 0); src_data = 16'($urandom);
      src_valid = !(m_run && m_pos == drop_pos);
      cycle();
    end
    check_eq("t3_underrun_sticky", underrun, 1'b1);
    src_valid = 1'b1;

    // Continuous frames with random drops, en_req changes, ignored starts, then stop.
    cont = 1'b1; en_req = 1'b0;
    stop_at = 3 * (VBC + LINE_CYC) + $urandom_range(0, LINE_CYC);
    fd_cnt = 0;
    for (int i = 0; i < stop_at + 2 * (VBC + LINE_CYC) + 10; i++) begin
      start = (i == 0) || (i < stop_at && $urandom_range(0, 15) == 0);
      stop = (i >= stop_at) && (i < stop_at + 3);
      if (i % 23 == 7) en_req = 1'($urandom_range(0, 1));
      src_valid = ($urandom_range(0, 7) != 0);
      src_data = 16'($urandom);
      cycle();
    end
    start = 1'b0; stop = 1'b0;
    check_eq("t5_idle_after_stop", busy, 1'b0);
    check_eq("t5_frames_done", fd_cnt, 4);

`ifdef CANNY_CTRL_OUT_MON_EN
    mon_frame(3);
    check_eq("t6_mon_ok", mon_err, 1'b0);
    mon_frame(2);
    check_eq("t6_mon_bad", mon_err, 1'b1);
`endif

    // Reset in the middle of LINE.
    cont = 1'b0; src_valid = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 200 && !(m_run && m_pos == VBC + HT + 3); i++) cycle();
    check_eq("t6_in_line", b_fval, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
